lcd_cfah_emul: RTL and testbench
================================

// Module: lcd_cfah_emul
// PURPOSE
// - Cycle-based behavioural model of a Crystalfontz CFAH (HD44780-class) character LCD, for testbench use.
// - Connects to the DUT's LCD bus (rs/rw/en/data).
// - Captures every write and reports it to the sequencer through o_rdata/o_rdata_val.
// - Answers bus reads with a busy-flag/address word or with a sequencer-supplied byte.
// PARAMETERS
// - G_RECEIVED_CMD_BUFFER_SIZE  256  depth of the circular log of received {rs,data} writes; power of 2, >=2.
// PORTS
// - clk                   in     1  single clock; all logic rising-edge.
// - rst_n                 in     1  asynchronous active-low reset.
// - i_rs                  in     1  LCD register select: 0 = instruction/status, 1 = data.
// - i_rw                  in     1  LCD read/not-write: 1 = read.
// - i_en                  in     1  LCD enable; a transfer completes on its falling edge.
// - io_data               inout  8  LCD data bus.
// - i_busy_flag_duration  in     8  busy time in clk cycles after each write; 0 = never busy.
// - i_wdata               in     8  byte returned on reads when i_wdata_sel=1.
// - i_wdata_sel           in     1  read-data select: 0 = autonomous response, 1 = return i_wdata.
// - o_rdata               out    8  last byte written by the DUT.
// - o_rdata_val           out    1  1-cycle strobe: o_rdata is updated.
// BEHAVIOUR
// - Reset values: o_rdata=8'h00, o_rdata_val=0, busy counter=0 (BF=0), address counter AC=7'h00, buffer write pointer=0, cmd_count=0.
// - en_q is i_en registered once. fall = en_q & ~i_en. Inputs are synchronous to clk; no resynchroniser.
// - Write transfer (fall with i_rw=0):
//   - Next cycle: o_rdata = io_data, o_rdata_val = 1 for exactly one cycle.
//   - {i_rs,io_data} is stored at buffer[wr_ptr]; wr_ptr increments and wraps to 0.
//   - When full, the buffer overwrites the oldest entry. cmd_count saturates at G_RECEIVED_CMD_BUFFER_SIZE.
//   - The busy counter loads i_busy_flag_duration.
// - Busy flag:
//   - BF = (busy counter != 0). The counter decrements each clk while nonzero.
//   - A write while busy is still accepted and reloads the counter; no error is raised.
// - AC update on a write, applied in the same cycle as the strobe:
//   - rs=1: AC+1, wraps 7'h7F -> 7'h00.
//   - rs=0, data[7]=1 (Set DDRAM address): AC = data[6:0].
//   - rs=0, data = 8'h01 (clear) or 8'b0000_001x (home): AC = 0.
//   - Other instructions leave AC unchanged.
// - Read transfer (i_rw=1 & i_en=1): io_data is driven combinationally, otherwise 8'hzz. Source:
//   - i_wdata_sel=1: i_wdata.
//   - i_wdata_sel=0, rs=0: {BF, AC}.
//   - i_wdata_sel=0, rs=1: data byte of the most recent rs=1 write (8'h00 if none).
// - Read completion: a fall with i_rw=1 and rs=1 increments AC (wrapping). Reads never pulse o_rdata_val.
// - Simultaneous events: a fall completing a write on the same cycle the counter would reach 0 reloads the counter; the reload wins.
// - Reset mid-transfer: all state clears immediately, the bus is released, and an in-flight strobe is dropped.
// CONFIGURATION
// - LCD_CFAH_EMUL_LOG_EN defined:
//   - Each captured write is printed with $display: time, "CMD"/"DATA", hex byte, AC after update.
//   - A write while BF=1 prints a "write while busy" warning.
// - LCD_CFAH_EMUL_LOG_EN undefined: no messages; functionally identical.
// STRUCTURE
// - Package lcd_cfah_emul_pkg holds:
//   - constants C_CMD_CLEAR=8'h01, C_CMD_HOME_MASK=8'hFE / C_CMD_HOME=8'h02, C_SET_DDRAM_BIT=7;
//   - typedef struct packed {logic rs; logic [7:0] data;} lcd_entry_t.
// - Sub-module lcd_busy_timer: 8-bit load/decrement counter with load, load_val and busy outputs.
// - Buffer array cmd_buffer, wr_ptr and cmd_count are internal, hierarchically readable signals.
// TESTING
// - Write: rs=0, rw=0, data=8'h38, en 1->0, busy duration=10.
//   - o_rdata=8'h38 and o_rdata_val high for one cycle after the fall.
//   - BF=1 for exactly 10 cycles.
//   - cmd_buffer[0]={0,8'h38}.
// - Busy poll: i_wdata_sel=0, rs=0, rw=1, en=1 three cycles after that write.
//   - io_data=8'h80|AC. After expiry, io_data[7]=0.
// - Address: write 8'h85, then data 8'h41.
//   - A status read returns 8'h06 once idle.
//   - Write 8'h01; a status read returns 8'h00.
// - Override read: i_wdata_sel=1, i_wdata=8'hA5, read with rs=0 -> io_data=8'hA5 regardless of BF. io_data=z when en=0.
// - Wrap: 258 writes with G=256 -> wr_ptr=2, cmd_buffer[0] holds write #257, cmd_count=256.
// - Reset mid-busy: assert rst_n=0 while BF=1 -> BF=0, AC=0, o_rdata=0, bus released immediately.

Source files
------------

// File: rtl/lcd_cfah_emul_pkg.sv
// Shared HD44780 instruction constants, the {rs,data} log entry type and the address-counter rule.
// Pure declarations: no latency, no flow control.
package lcd_cfah_emul_pkg;

    localparam logic [7:0] C_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] C_CMD_HOME_MASK = 8'hFE;
    localparam logic [7:0] C_CMD_HOME      = 8'h02;
    localparam int         C_SET_DDRAM_BIT = 7;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    // Home ignores bit 0, so 8'h02 and 8'h03 both reset the address.
    function automatic logic [6:0] f_ac_after_write(input logic [6:0] ac,
                                                    input logic       rs,
                                                    input logic [7:0] dat);
        logic [6:0] nxt;
        nxt = ac;
        if (rs) begin
            nxt = ac + 7'd1;
        end else if (dat[C_SET_DDRAM_BIT]) begin
            nxt = dat[6:0];
        end else if ((dat == C_CMD_CLEAR) || ((dat & C_CMD_HOME_MASK) == C_CMD_HOME)) begin
            nxt = 7'h00;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_cfah_emul_busy_timer.sv
// Busy-flag timer: loads a cycle count, decrements to zero; load beats the final decrement.
// Busy is combinational from the count, one edge after load; no flow control.
module lcd_busy_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_busy
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_busy = (r_cnt != 8'd0);

endmodule

// File: rtl/lcd_cfah_emul.sv
// CFAH character-LCD bus model: logs writes, strobes o_rdata one cycle after the en fall, answers reads combinationally.
// No backpressure: writes while busy are accepted and restart the timer. Define LCD_CFAH_EMUL_LOG_EN to print each write.
module lcd_cfah_emul
    import lcd_cfah_emul_pkg::*;
#(
    parameter int G_RECEIVED_CMD_BUFFER_SIZE = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic       i_en,
    inout  wire  [7:0] io_data,
    input  logic [7:0] i_busy_flag_duration,
    input  logic [7:0] i_wdata,
    input  logic       i_wdata_sel,
    output logic [7:0] o_rdata,
    output logic       o_rdata_val
);

    localparam int C_PTR_W = $clog2(G_RECEIVED_CMD_BUFFER_SIZE);

    logic               r_en_q;
    logic [6:0]         r_ac;
    logic [7:0]         r_last_data;
    logic               w_fall;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic               w_bf;
    logic               w_drive;
    logic [6:0]         w_ac_nxt;
    logic [7:0]         w_rd_dat;

    lcd_entry_t         cmd_buffer [G_RECEIVED_CMD_BUFFER_SIZE];
    logic [C_PTR_W-1:0] wr_ptr;
    logic [C_PTR_W:0]   cmd_count;

    assign w_fall    = r_en_q & ~i_en;
    assign w_wr_fire = w_fall & ~i_rw;
    assign w_rd_fire = w_fall & i_rw & i_rs;

    always_comb begin
        w_ac_nxt = r_ac;
        if (w_wr_fire) begin
            w_ac_nxt = f_ac_after_write(r_ac, i_rs, io_data);
        end else if (w_rd_fire) begin
            w_ac_nxt = r_ac + 7'd1;
        end
    end

    always_comb begin
        w_rd_dat = r_last_data;
        if (i_wdata_sel) begin
            w_rd_dat = i_wdata;
        end else if (!i_rs) begin
            w_rd_dat = {w_bf, r_ac};
        end
    end

    // Reset also gates the driver so the bus is freed without waiting for a clock.
    assign w_drive = rst_n & i_rw & i_en;
    assign io_data = w_drive ? w_rd_dat : 8'hzz;

    lcd_busy_timer u_busy_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_wr_fire),
        .i_load_val (i_busy_flag_duration),
        .o_busy     (w_bf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q      <= 1'b0;
            r_ac        <= 7'h00;
            r_last_data <= 8'h00;
            o_rdata     <= 8'h00;
            o_rdata_val <= 1'b0;
            wr_ptr      <= '0;
            cmd_count   <= '0;
        end else begin
            r_en_q      <= i_en;
            r_ac        <= w_ac_nxt;
            o_rdata_val <= w_wr_fire;
            if (w_wr_fire) begin
                o_rdata <= io_data;
                wr_ptr  <= wr_ptr + C_PTR_W'(1);
                // Depth is a power of two, so the count's MSB sets exactly at full.
                if (!cmd_count[C_PTR_W]) begin
                    cmd_count <= cmd_count + (C_PTR_W + 1)'(1);
                end
                if (i_rs) begin
                    r_last_data <= io_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            cmd_buffer[wr_ptr] <= '{rs: i_rs, data: io_data};
        end
    end

`ifdef LCD_CFAH_EMUL_LOG_EN
    always @(posedge clk) begin
        if (rst_n && w_wr_fire) begin
            if (w_bf) begin
                $display("%0t lcd_cfah_emul: write while busy", $time);
            end
            $display("%0t lcd_cfah_emul: %s %02h AC=%02h", $time,
                     i_rs ? "DATA" : "CMD", io_data, w_ac_nxt);
        end
    end
`else
`endif

endmodule

// File: tb/tb_lcd_cfah_emul.sv
// Bench for lcd_cfah_emul: directed bus transactions plus random traffic, checked each cycle against a transaction-level model.
module tb_lcd_cfah_emul;

    localparam int G = 256;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rs     = 1'b0;
    logic       rw     = 1'b0;
    logic       en     = 1'b0;
    logic       wsel   = 1'b0;
    logic       tb_drv = 1'b0;
    logic [7:0] dur    = 8'd0;
    logic [7:0] wdata  = 8'd0;
    logic [7:0] tb_dat = 8'd0;
    wire  [7:0] lcd_data;
    logic [7:0] o_rdata;
    logic       o_rdata_val;

    assign lcd_data = tb_drv ? tb_dat : 8'hzz;
    always #5 clk = ~clk;

    lcd_cfah_emul #(.G_RECEIVED_CMD_BUFFER_SIZE(G)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_rs                 (rs),
        .i_rw                 (rw),
        .i_en                 (en),
        .io_data              (lcd_data),
        .i_busy_flag_duration (dur),
        .i_wdata              (wdata),
        .i_wdata_sel          (wsel),
        .o_rdata              (o_rdata),
        .o_rdata_val          (o_rdata_val)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: absolute cycle numbers for strobe and busy expiry, plus a flat write log.
    int         cyc      = 0;
    int         busy_end = 0;
    int         wr_cyc   = -1;
    int         m_ac     = 0;
    int         m_total  = 0;
    int         cmp_idx  = 0;
    int         bf_cnt   = 0;
    logic [7:0] m_rdata  = 8'h00;
    logic [7:0] m_last   = 8'h00;
    logic [8:0] m_buf [G];
    bit         chk_on   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_read();
        if (wsel) return wdata;
        if (!rs) return {cyc < busy_end, 7'(m_ac)};
        return m_last;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic model_reset();
        busy_end = 0;
        wr_cyc   = -1;
        m_ac     = 0;
        m_rdata  = 8'h00;
        m_last   = 8'h00;
        m_total  = 0;
    endtask

    task automatic model_write(input logic r, input logic [7:0] d, input logic [7:0] du);
        m_buf[m_total % G] = {r, d};
        m_total++;
        wr_cyc   = cyc;
        m_rdata  = d;
        busy_end = cyc + int'(du);
        if (r) begin
            m_ac   = (m_ac + 1) % 128;
            m_last = d;
        end else if (d >= 8'h80) begin
            m_ac = int'(d) - 128;
        end else if (d == 8'h01 || d == 8'h02 || d == 8'h03) begin
            m_ac = 0;
        end
    endtask

    task automatic lcd_write(input logic r, input logic [7:0] d, input logic [7:0] du);
        rs = r; rw = 1'b0; tb_drv = 1'b1; tb_dat = d; dur = du; en = 1'b1;
        step();
        en = 1'b0;
        step();
        model_write(r, d, du);
    endtask

    task automatic lcd_read(input logic r, input logic s, input logic [7:0] wd, input int hold);
        tb_drv = 1'b0; rw = 1'b1; rs = r; wsel = s; wdata = wd; en = 1'b1;
        repeat (hold) step();
        en = 1'b0;
        step();
        if (r) m_ac = (m_ac + 1) % 128;
    endtask

    task automatic peek_read(input string nm, input logic r, input logic s,
                             input logic [7:0] wd, input logic [7:0] expv);
        tb_drv = 1'b0; rw = 1'b1; rs = r; wsel = s; wdata = wd; en = 1'b1;
        #1 check(nm, 32'(lcd_data), 32'(expv));
        step();
        en = 1'b0;
        step();
        if (r) m_ac = (m_ac + 1) % 128;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("rdata_val", 32'(o_rdata_val), 32'(cyc == wr_cyc));
            check("rdata", 32'(o_rdata), 32'(m_rdata));
            check("wr_ptr", 32'(dut.wr_ptr), 32'(m_total % G));
            check("cmd_count", 32'(dut.cmd_count), 32'((m_total < G) ? m_total : G));
            if (tb_drv) begin
                check("bus_release", 32'(lcd_data), 32'(tb_dat));
            end else if (rst_n && rw && en) begin
                check("rd_bus", 32'(lcd_data), 32'(exp_read()));
            end
            if (rst_n && m_total > 0) begin
                cmp_idx = (m_total - 1) % G;
                check("buf_last", 32'({dut.cmd_buffer[cmp_idx].rs, dut.cmd_buffer[cmp_idx].data}),
                      32'(m_buf[cmp_idx]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("reset_rdata", 32'(o_rdata), 32'h00);
        check("reset_val", 32'(o_rdata_val), 32'h0);
        check("reset_ptr", 32'(dut.wr_ptr), 32'h0);
        check("reset_cnt", 32'(dut.cmd_count), 32'h0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        step();
        peek_read("reset_status", 1'b0, 1'b0, 8'h00, 8'h00);

        // Function set with a 10-cycle busy window.
        lcd_write(1'b0, 8'h38, 8'd10);
        check("wr38_rdata", 32'(o_rdata), 32'h38);
        check("wr38_val", 32'(o_rdata_val), 32'h1);
        check("wr38_buf", 32'({dut.cmd_buffer[0].rs, dut.cmd_buffer[0].data}), 32'h038);
        step();
        step();
        tb_drv = 1'b0; rw = 1'b1; rs = 1'b0; wsel = 1'b0; en = 1'b1;
        #1 check("busy_poll", 32'(lcd_data), 32'h80);
        bf_cnt = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            #1 if (lcd_data[7]) bf_cnt++;
        end
        check("bf_cycles_from_fall", 32'(bf_cnt + 2), 32'd10);
        check("bf_expired", 32'(lcd_data[7]), 32'h0);
        en = 1'b0;
        step();

        // Address counter: set DDRAM 5, one data write, then clear.
        lcd_write(1'b0, 8'h85, 8'd0);
        lcd_write(1'b1, 8'h41, 8'd0);
        step();
        peek_read("addr_status", 1'b0, 1'b0, 8'h00, 8'h06);
        lcd_write(1'b0, 8'h01, 8'd0);
        peek_read("clear_status", 1'b0, 1'b0, 8'h00, 8'h00);

        // Override read while busy, then bus released with en low.
        lcd_write(1'b0, 8'h0C, 8'd20);
        peek_read("override", 1'b0, 1'b1, 8'hA5, 8'hA5);
        rw = 1'b1; en = 1'b0; wsel = 1'b1; wdata = 8'hA5; tb_drv = 1'b1; tb_dat = 8'h5A;
        #1 check("release_en_low", 32'(lcd_data), 32'h5A);
        step();
        tb_drv = 1'b0; wsel = 1'b0;
        repeat (20) step();

        // Reload on the cycle the counter would otherwise reach zero.
        lcd_write(1'b0, 8'h0C, 8'd3);
        step();
        lcd_write(1'b0, 8'h14, 8'd4);
        peek_read("reload_wins", 1'b0, 1'b0, 8'h00, 8'h80);
        lcd_read(1'b0, 1'b0, 8'h00, 5);

        // Reset while busy and with a strobe in flight.
        lcd_write(1'b0, 8'h85, 8'd20);
        rst_n = 1'b0; rw = 1'b1; en = 1'b1; rs = 1'b0; wsel = 1'b1; wdata = 8'hC3;
        tb_drv = 1'b1; tb_dat = 8'h3C;
        model_reset();
        #1;
        check("rst_bus_free", 32'(lcd_data), 32'h3C);
        check("rst_mid_rdata", 32'(o_rdata), 32'h00);
        check("rst_mid_val", 32'(o_rdata_val), 32'h0);
        step();
        en = 1'b0; rw = 1'b0; tb_drv = 1'b0; wsel = 1'b0; rst_n = 1'b1;
        step();
        peek_read("rst_mid_status", 1'b0, 1'b0, 8'h00, 8'h00);

        // Log wrap: 258 data writes into 256 entries.
        for (int i = 1; i <= 258; i++) lcd_write(1'b1, 8'(i), 8'd0);
        check("wrap_ptr", 32'(dut.wr_ptr), 32'd2);
        check("wrap_cnt", 32'(dut.cmd_count), 32'd256);
        check("wrap_buf0", 32'({dut.cmd_buffer[0].rs, dut.cmd_buffer[0].data}), 32'h101);
        peek_read("wrap_ac", 1'b0, 1'b0, 8'h00, 8'h02);
        peek_read("data_read", 1'b1, 1'b0, 8'h00, 8'h02);
        peek_read("ac_after_data_read", 1'b0, 1'b0, 8'h00, 8'h03);

        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 3))
                0, 1: lcd_write(1'($urandom), 8'($urandom), 8'($urandom_range(0, 12)));
                2: lcd_read(1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom),
                            int'($urandom_range(1, 4)));
                default: begin
                    en = 1'b0; tb_drv = 1'b0; rw = 1'($urandom);
                    repeat ($urandom_range(1, 3)) step();
                end
            endcase
        end
        en = 1'b0; tb_drv = 1'b0;
        step();
        step();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
